// File: rtl/modulation_ctrl_pkg.sv
// modulation_ctrl_pkg: register map, sequencer states
// and reset defaults shared by the modulation control slice.
package modulation_ctrl_pkg;

   localparam logic [2:0] A_FREQ   = 3'd0;
   localparam logic [2:0] A_AMP_H  = 3'd1;
   localparam logic [2:0] A_AMP_L  = 3'd2;
   localparam logic [2:0] A_DLY    = 3'd3;
   localparam logic [2:0] A_SETTLE = 3'd4;

   localparam logic [31:0] FREQ_RST = 32'd100;

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      SETTLE
   } state_t;

endpackage

// File: rtl/mod_sample_sched.sv
// mod_sample_sched: delays each generator step into a sample
// strobe, flags overrun steps and blanks strobes while settling.
module mod_sample_sched
   import modulation_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step,
   input  logic        status,
   input  logic [15:0] dly,
   input  logic        blank,
   output logic        sample_trig,
   output logic        sample_phase,
   output logic        sample_miss
);

   logic        pend;
   logic        cap;
   logic [15:0] cnt;

   // delay countdown; a new step always restarts the countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend         <= 1'b0;
         cap          <= 1'b0;
         cnt          <= '0;
         sample_trig  <= 1'b0;
         sample_phase <= 1'b0;
         sample_miss  <= 1'b0;
      end else begin
         sample_trig <= 1'b0;
         sample_miss <= 1'b0;
         if (step) begin
            sample_miss <= pend & ~blank;
            pend        <= 1'b1;
            cnt         <= dly;
            cap         <= status;
         end else if (pend) begin
            if (cnt == 16'd0) begin
               pend         <= 1'b0;
               sample_trig  <= ~blank;
               sample_phase <= cap;
            end else begin
               cnt <= cnt - 16'd1;
            end
         end
      end
   end

endmodule

// File: rtl/modulation_ctrl.sv
// modulation_ctrl: shadow/active config committed on HIGH->LOW
// period boundaries, post-commit blanking, sample scheduling.
module modulation_ctrl
   import modulation_ctrl_pkg::*;
#(
   parameter int OUTPUT_BIT = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_en,
   input  logic [2:0]            i_wr_addr,
   input  logic [31:0]           i_wr_data,
   input  logic                  i_commit,
   input  logic                  i_status,
   input  logic                  i_step_trig,
   output logic [31:0]           o_freq_cnt,
   output logic [OUTPUT_BIT-1:0] o_amp_H,
   output logic [OUTPUT_BIT-1:0] o_amp_L,
   output logic                  o_busy,
   output logic                  o_settle,
   output logic                  o_sample_trig,
   output logic                  o_sample_phase,
   output logic                  o_sample_miss
);

   logic [31:0]           sh_freq;
   logic [OUTPUT_BIT-1:0] sh_amp_h;
   logic [OUTPUT_BIT-1:0] sh_amp_l;
   logic [15:0]           sh_dly;
   logic [15:0]           act_dly;
   logic [7:0]            sh_per;
   logic [7:0]            per_cnt;
   logic                  status_q;
   logic                  bnd;
   logic                  skip;
   logic                  fall;
   logic                  take;
   logic                  apply;
   state_t                state;
   state_t                nxt;

   assign fall = status_q & ~i_status;
   assign take = i_commit & (state != PENDING);

   // host writes always land in the shadow set
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sh_freq  <= FREQ_RST;
         sh_amp_h <= '0;
         sh_amp_l <= '0;
         sh_dly   <= '0;
         sh_per   <= '0;
      end else if (i_wr_en) begin
         case (i_wr_addr)
            A_FREQ:   sh_freq  <= i_wr_data;
            A_AMP_H:  sh_amp_h <= i_wr_data[OUTPUT_BIT-1:0];
            A_AMP_L:  sh_amp_l <= i_wr_data[OUTPUT_BIT-1:0];
            A_DLY:    sh_dly   <= i_wr_data[15:0];
            A_SETTLE: sh_per   <= i_wr_data[7:0];
            default:  ;
         endcase
      end
   end

   // boundary pulse; a fall seen in the commit cycle is skipped
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         status_q <= 1'b0;
         bnd      <= 1'b0;
         skip     <= 1'b0;
      end else begin
         status_q <= i_status;
         bnd      <= fall;
         skip     <= take & fall;
      end
   end

   // sequencer next state and apply decision
   always_comb begin
      nxt   = state;
      apply = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_commit) nxt = PENDING;
         end
         PENDING: begin
            if (bnd && !skip) begin
               apply = 1'b1;
               nxt   = (sh_per == 8'd0) ? IDLE : SETTLE;
            end
         end
         SETTLE: begin
            if (i_commit) nxt = PENDING;
            else if (bnd && per_cnt == 8'd1) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // state register with registered status flags
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         o_busy   <= 1'b0;
         o_settle <= 1'b0;
      end else begin
         state    <= nxt;
         o_busy   <= (nxt == PENDING);
         o_settle <= (nxt == SETTLE);
      end
   end

   // atomic apply of the whole set and blanking period count
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_freq_cnt <= FREQ_RST;
         o_amp_H    <= '0;
         o_amp_L    <= '0;
         act_dly    <= '0;
         per_cnt    <= '0;
      end else if (apply) begin
         o_freq_cnt <= sh_freq;
         o_amp_H    <= sh_amp_h;
         o_amp_L    <= sh_amp_l;
         act_dly    <= sh_dly;
         per_cnt    <= sh_per;
      end else if (state == SETTLE && bnd && !i_commit) begin
         per_cnt <= per_cnt - 8'd1;
      end
   end

   mod_sample_sched u_sched (
      .clk          (i_clk),
      .rst_n        (i_rst_n),
      .step         (i_step_trig),
      .status       (i_status),
      .dly          (act_dly),
      .blank        (o_settle),
      .sample_trig  (o_sample_trig),
      .sample_phase (o_sample_phase),
      .sample_miss  (o_sample_miss)
   );

endmodule

// File: tb/tb_modulation_ctrl.sv
// tb_modulation_ctrl: directed stimulus pushes cycle-stamped
// expectations; a negedge monitor pops and compares them.
module tb_modulation_ctrl;
   import modulation_ctrl_pkg::*;

   typedef enum int {
      S_FREQ, S_AMPH, S_AMPL, S_BUSY,
      S_SETTLE, S_TRIG, S_PHASE, S_MISS
   } sig_e;

   typedef struct {
      int          cyc;
      sig_e        sig;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   cyc  = 0;
   int   ncmp = 0;
   int   nbad = 0;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        wr_en = 0;
   logic [2:0]  wr_addr = 0;
   logic [31:0] wr_data = 0;
   logic        commit = 0;
   logic        status = 0;
   logic        step = 0;
   logic [31:0] freq;
   logic [31:0] amp_h;
   logic [31:0] amp_l;
   logic        busy;
   logic        settle;
   logic        trig;
   logic        phase;
   logic        miss;

   modulation_ctrl #(.OUTPUT_BIT(32)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_wr_en        (wr_en),
      .i_wr_addr      (wr_addr),
      .i_wr_data      (wr_data),
      .i_commit       (commit),
      .i_status       (status),
      .i_step_trig    (step),
      .o_freq_cnt     (freq),
      .o_amp_H        (amp_h),
      .o_amp_L        (amp_l),
      .o_busy         (busy),
      .o_settle       (settle),
      .o_sample_trig  (trig),
      .o_sample_phase (phase),
      .o_sample_miss  (miss)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] value(sig_e s);
      case (s)
         S_FREQ:   return freq;
         S_AMPH:   return amp_h;
         S_AMPL:   return amp_l;
         S_BUSY:   return {31'd0, busy};
         S_SETTLE: return {31'd0, settle};
         S_TRIG:   return {31'd0, trig};
         S_PHASE:  return {31'd0, phase};
         default:  return {31'd0, miss};
      endcase
   endfunction

   always @(negedge clk) begin : mon
      bit          st;
      bit          sm;
      logic [31:0] act;
      st = 0;
      sm = 0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc < cyc) begin
            ncmp++;
            nbad++;
            $display("FAIL stale_%s cyc=%0d", q[i].sig.name(), q[i].cyc);
            q.delete(i);
         end else if (q[i].cyc == cyc) begin
            act = value(q[i].sig);
            if (q[i].sig == S_TRIG) st = 1;
            if (q[i].sig == S_MISS) sm = 1;
            ncmp++;
            if (act !== q[i].val) begin
               nbad++;
               $display("FAIL %s cyc=%0d got=%0h want=%0h",
                        q[i].sig.name(), cyc, act, q[i].val);
            end
            q.delete(i);
         end
      end
      if (trig === 1'b1 && !st) begin
         ncmp++;
         nbad++;
         $display("FAIL unexpected_trig cyc=%0d got=1 want=0", cyc);
      end
      if (miss === 1'b1 && !sm) begin
         ncmp++;
         nbad++;
         $display("FAIL unexpected_miss cyc=%0d got=1 want=0", cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex(int c, sig_e s, logic [31:0] v);
      q.push_back('{c, s, v});
   endtask

   task automatic wr(logic [2:0] a, logic [31:0] d, logic cm);
      wr_en   = 1;
      wr_addr = a;
      wr_data = d;
      commit  = cm;
      tick();
      wr_en  = 0;
      commit = 0;
   endtask

   task automatic hi();
      status = 1;
      tick();
      tick();
   endtask

   task automatic lo();
      status = 0;
      tick();
      tick();
      tick();
   endtask

   task automatic stp();
      step = 1;
      tick();
      step = 0;
   endtask

   initial begin
      int f;
      int s;
      int last;
      tick();
      tick();
      rst_n = 1;
      f = cyc;
      ex(f + 1, S_FREQ, 100);
      ex(f + 1, S_AMPH, 0);
      ex(f + 1, S_AMPL, 0);
      ex(f + 1, S_BUSY, 0);
      ex(f + 1, S_SETTLE, 0);
      ex(f + 1, S_MISS, 0);
      tick();

      // zero delay: strobe the cycle after the step
      s = cyc;
      ex(s + 1, S_TRIG, 0);
      ex(s + 2, S_TRIG, 1);
      ex(s + 2, S_PHASE, 0);
      stp();
      tick();
      tick();

      // atomic apply, write while pending joins the commit
      hi();
      wr(A_FREQ, 32'd20, 0);
      wr(A_AMP_H, 32'd1000, 0);
      wr(A_AMP_L, 32'hFFFF_FC18, 0);
      ex(cyc + 1, S_BUSY, 1);
      wr(3'd5, 32'd7, 1);
      wr(A_AMP_H, 32'd500, 0);
      tick();
      f = cyc;
      ex(f + 1, S_FREQ, 100);
      ex(f + 1, S_AMPH, 0);
      ex(f + 1, S_AMPL, 0);
      ex(f + 1, S_BUSY, 1);
      ex(f + 2, S_FREQ, 20);
      ex(f + 2, S_AMPH, 500);
      ex(f + 2, S_AMPL, 32'hFFFF_FC18);
      ex(f + 2, S_BUSY, 0);
      ex(f + 2, S_SETTLE, 0);
      lo();

      // commit in the falling cycle waits for the next boundary
      wr(A_FREQ, 32'd40, 0);
      hi();
      f = cyc;
      ex(f + 1, S_BUSY, 1);
      ex(f + 2, S_FREQ, 20);
      ex(f + 2, S_BUSY, 1);
      status = 0;
      commit = 1;
      tick();
      commit = 0;
      tick();
      tick();
      hi();
      f = cyc;
      ex(f + 1, S_BUSY, 1);
      ex(f + 2, S_FREQ, 40);
      ex(f + 2, S_BUSY, 0);
      lo();

      // blanking for three boundaries after the apply
      wr(A_DLY, 32'd5, 0);
      wr(A_SETTLE, 32'd3, 1);
      hi();
      f = cyc;
      ex(f + 1, S_SETTLE, 0);
      ex(f + 2, S_SETTLE, 1);
      ex(f + 2, S_BUSY, 0);
      lo();
      s = cyc;
      ex(s + 3, S_MISS, 0);
      ex(s + 7, S_TRIG, 0);
      ex(s + 9, S_TRIG, 0);
      stp();
      tick();
      stp();
      repeat (8) tick();
      hi();
      lo();
      hi();
      f = cyc;
      ex(f + 2, S_SETTLE, 1);
      lo();
      hi();
      f = cyc;
      ex(f + 1, S_SETTLE, 1);
      ex(f + 2, S_SETTLE, 0);
      lo();

      // strobes resume with the captured phase
      s = cyc;
      ex(s + 6, S_TRIG, 0);
      ex(s + 7, S_TRIG, 1);
      ex(s + 7, S_PHASE, 0);
      stp();
      repeat (8) tick();
      hi();
      s = cyc;
      ex(s + 7, S_TRIG, 1);
      ex(s + 7, S_PHASE, 1);
      stp();
      repeat (8) tick();

      // delay longer than the step spacing: every later step misses
      wr(A_DLY, 32'd30, 0);
      wr(A_FREQ, 32'd10, 0);
      wr(A_SETTLE, 32'd0, 1);
      f = cyc;
      ex(f + 2, S_FREQ, 10);
      ex(f + 2, S_BUSY, 0);
      ex(f + 2, S_SETTLE, 0);
      lo();
      last = cyc;
      for (int k = 0; k < 4; k++) begin
         s = cyc;
         last = s;
         ex(s + 1, S_MISS, (k == 0) ? 32'd0 : 32'd1);
         stp();
         repeat (9) tick();
      end
      ex(last + 32, S_TRIG, 0);

      // reset while pending with a sample in flight
      ex(cyc + 1, S_BUSY, 1);
      wr(A_FREQ, 32'd77, 1);
      tick();
      rst_n = 0;
      f = cyc;
      ex(f, S_BUSY, 0);
      ex(f, S_FREQ, 100);
      tick();
      tick();
      rst_n = 1;
      tick();
      hi();
      f = cyc;
      ex(f + 2, S_FREQ, 100);
      ex(f + 2, S_BUSY, 0);
      lo();
      repeat (30) tick();

      if (q.size() != 0) begin
         ncmp++;
         nbad++;
         $display("FAIL leftover got=%0d want=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule

// File: doc/modulation_ctrl.md
# modulation_ctrl

Configuration sequencer and sample scheduler for the PIG square-wave modulation generator. Host register writes land in shadow registers and are committed atomically to the generator's frequency and amplitude inputs only at a modulation period boundary, so the generator never sees a torn H/L pair or a half-period of mixed settings. The block also schedules the ADC/demodulator sample strobe at a programmed delay after each modulation step, and blanks sampling for a programmed number of periods after every commit.

## Interface
- OUTPUT_BIT, 32, width of amplitude words (matches generator)
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wr_en  in  1  host register write strobe
- i_wr_addr  in  3  register address: 0 FREQ_CNT, 1 AMP_H, 2 AMP_L, 3 SAMPLE_DLY, 4 SETTLE_PER; 5-7 ignored
- i_wr_data  in  32  write data (SAMPLE_DLY uses [15:0], SETTLE_PER uses [7:0])
- i_commit  in  1  request to apply shadow set at next boundary
- i_status  in  1  generator half-period state (0 LOW, 1 HIGH)
- i_step_trig  in  1  generator one-cycle edge pulse
- o_freq_cnt  out  32  active half-period count to generator
- o_amp_H / o_amp_L  out  OUTPUT_BIT  active amplitudes to generator
- o_busy  out  1  commit pending
- o_settle  out  1  post-commit blanking active
- o_sample_trig  out  1  one-cycle sample strobe
- o_sample_phase  out  1  i_status captured at the step that scheduled the strobe
- o_sample_miss  out  1  one-cycle pulse: pending sample dropped by a new step

## Operation
- Reset: shadow and active FREQ_CNT=100, amps=0, SAMPLE_DLY=0, SETTLE_PER=0; all 1-bit outputs 0; FSM IDLE.
- Writes always update shadow (all states); invalid addresses have no effect. Write and commit in the same cycle: the write is included in the commit.
- Boundary = registered i_status HIGH->LOW transition (detected one cycle after i_status falls).
- FSM IDLE: i_commit -> PENDING.
- PENDING: o_busy=1; extra i_commit ignored. At the first boundary strictly after the commit cycle: all five active registers <- shadow in one cycle; if SETTLE_PER=0 -> IDLE, else load period counter with SETTLE_PER -> SETTLE.
- SETTLE: o_settle=1; each boundary decrements counter; reaching 0 -> IDLE. i_commit -> PENDING (o_settle drops, blanking restarts after the next apply).
- Sample scheduler: i_step_trig loads delay counter with active SAMPLE_DLY and captures i_status. Expiry -> o_sample_trig for one cycle with o_sample_phase = captured value. SAMPLE_DLY=0 -> strobe the cycle after i_step_trig.
- i_step_trig while a sample is pending: o_sample_miss pulses, counter reloads, old sample dropped.
- While o_settle=1, expiries produce no o_sample_trig and no miss; scheduling continues.
- Reset mid-operation: everything returns to reset values immediately; pending commit and pending sample discarded.

## Timing
- Active registers change 2 cycles after i_status falls (1 sync/edge register + 1 apply).
- o_busy rises the cycle after i_commit and falls with the apply.
- o_settle rises with the apply cycle +1, falls the cycle after the final boundary.
- o_sample_trig asserted SAMPLE_DLY+1 cycles after i_step_trig.
- All outputs registered; no combinational input-to-output paths.

## Structure
- Package modulation_ctrl_pkg: address constants, FSM state enum (IDLE, PENDING, SETTLE), reset defaults (FREQ 100, amps 0).
- Sub-module mod_sample_sched: delay counter, phase capture, settle gating, miss detection.
- Top holds shadow/active register files, boundary detector and FSM.

## Test plan
- Write FREQ_CNT=20, AMP_H=1000, AMP_L=-1000, commit mid-HIGH -> o_busy until boundary; all three active values change in the same cycle, 2 cycles after i_status falls.
- Write AMP_H=500 while PENDING, no second commit -> 500 applied at the same boundary.
- SETTLE_PER=3, SAMPLE_DLY=5, commit -> o_settle high for exactly 3 boundaries; no o_sample_trig during it; first strobe 6 cycles after the next i_step_trig.
- SAMPLE_DLY=30 with FREQ_CNT=10 -> o_sample_miss on every step, never o_sample_trig.
- Commit in the exact cycle i_status falls -> applied at the following boundary, not this one.
- Assert i_rst_n low while PENDING and a sample pending -> outputs at reset values, no strobe after release.
